// File: rtl/mem_arbiter_2port_if.sv
// mem_arbiter_2port_if: requester handshakes plus memory pin bundle
// for the two-port round-robin memory arbiter.
interface mem_arbiter_2port_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rE;
  logic              mem_wE;
  logic              mem_reset;
  logic [DATA_W-1:0] mem_dataOut;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1, busy,
    output mem_data, mem_address,
    output mem_rE, mem_wE, mem_reset,
    input  mem_dataOut
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1, busy,
    input  mem_data, mem_address,
    input  mem_rE, mem_wE, mem_reset,
    output mem_dataOut
  );
endinterface

// File: rtl/mem_arbiter_2port.sv
// mem_arbiter_2port: round-robin arbiter/sequencer serialising
// single-word reads/writes from two requesters onto one memory.
module mem_arbiter_2port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic clock,
  input  logic reset,
  mem_arbiter_2port_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              mre_q, mre_d;
  logic              mwe_q, mwe_d;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Tie goes to whoever did not win last.
  assign win = (bus.req0 & bus.req1) ? ~last_q
                                     : bus.req1;

  assign sel_we    = win ? bus.we1    : bus.we0;
  assign sel_addr  = win ? bus.addr1  : bus.addr0;
  assign sel_wdata = win ? bus.wdata1 : bus.wdata0;

  // Next state, grant latch, memory strobes and response.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mdata_d  = '0;
    maddr_d  = '0;
    mre_d    = 1'b0;
    mwe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = ACCESS;
          gnt_d   = win;
          last_d  = win;
          maddr_d = sel_addr;
          mwe_d   = sel_we;
          mre_d   = ~sel_we;
          mdata_d = sel_we ? sel_wdata : '0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        if (mre_q) begin
          if (gnt_q) rdata1_d = bus.mem_dataOut;
          else       rdata0_d = bus.mem_dataOut;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mdata_q  <= '0;
      maddr_q  <= '0;
      mre_q    <= 1'b0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mdata_q  <= mdata_d;
      maddr_q  <= maddr_d;
      mre_q    <= mre_d;
      mwe_q    <= mwe_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_data    = mdata_q;
  assign bus.mem_address = maddr_q;
  assign bus.mem_rE      = mre_q;
  assign bus.mem_wE      = mwe_q;
  assign bus.mem_reset   = reset;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// tb_mem_arbiter_2port: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter_2port;

  logic clock;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mem_arbiter_2port_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  mem_arbiter_2port #(.ADDR_W(5), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory behaviour: cleared by reset, write on edge, comb read.
  logic [31:0] mem_q [32];
  always @(posedge clock) begin
    if (bus.mem_reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (bus.mem_wE) begin
      mem_q[bus.mem_address] <= bus.mem_data;
    end
  end
  assign bus.mem_dataOut = bus.mem_rE ? mem_q[bus.mem_address] : '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input bit p, input bit we,
                         input logic [4:0] a, input logic [31:0] d);
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic drop();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 0, 5'd3, 32'd0);
    set_req(1, 0, 5'd4, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.mem_rE, bus.mem_wE} !== 5'b0 ||
          bus.mem_data !== 32'd0 || bus.mem_address !== 5'd0 ||
          bus.rdata0 !== 32'd0 || bus.rdata1 !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs: ack=%b%b busy=%b re=%b we=%b d=%h a=%h r0=%h r1=%h want all 0",
                 bus.ack0, bus.ack1, bus.busy, bus.mem_rE, bus.mem_wE,
                 bus.mem_data, bus.mem_address, bus.rdata0, bus.rdata1);
      end
      tests_run++;
      if (bus.mem_reset !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_mem_reset: got %b want 1", bus.mem_reset);
      end
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.mem_rE !== 1'b1 ||
        bus.mem_address !== 5'd3 || bus.mem_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_grant: busy=%b re=%b addr=%0d mrst=%b want 1 1 3 0",
               bus.busy, bus.mem_rE, bus.mem_address, bus.mem_reset);
    end
    step();
    tests_run++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_ack: ack0=%b ack1=%b want 1 0", bus.ack0, bus.ack1);
    end
    drop();
    step();
  endtask

  task automatic test_write_read();
    set_req(0, 1, 5'd5, 32'hDEADBEEF);
    step();
    tests_run++;
    if (bus.mem_wE !== 1'b1 || bus.mem_rE !== 1'b0 ||
        bus.mem_address !== 5'd5 || bus.mem_data !== 32'hDEADBEEF ||
        bus.ack0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_access: we=%b re=%b a=%0d d=%h ack0=%b want 1 0 5 deadbeef 0",
               bus.mem_wE, bus.mem_rE, bus.mem_address, bus.mem_data, bus.ack0);
    end
    step();
    tests_run++;
    if (bus.mem_wE !== 1'b0 || bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_resp: we=%b ack0=%b ack1=%b want 0 1 0",
               bus.mem_wE, bus.ack0, bus.ack1);
    end
    drop();
    step();
    set_req(0, 0, 5'd5, 32'd0);
    step();
    tests_run++;
    if (bus.mem_rE !== 1'b1 || bus.mem_wE !== 1'b0 || bus.mem_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd_access: re=%b we=%b d=%h want 1 0 0",
               bus.mem_rE, bus.mem_wE, bus.mem_data);
    end
    step();
    tests_run++;
    if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hDEADBEEF || bus.rdata1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd_resp: ack0=%b r0=%h r1=%h want 1 deadbeef 0",
               bus.ack0, bus.rdata0, bus.rdata1);
    end
    drop();
    step();
  endtask

  task automatic test_tie();
    int grants [$];
    int cycles [$];
    int both;
    both = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 0, 5'd1, 32'd0);
    set_req(1, 0, 5'd2, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.ack0 && bus.ack1) both++;
      if (bus.ack0) begin grants.push_back(0); cycles.push_back(c); end
      if (bus.ack1) begin grants.push_back(1); cycles.push_back(c); end
    end
    drop();
    step();
    tests_run++;
    if (grants.size() != 4 || both != 0) begin
      tests_failed++;
      $display("FAIL tie_count: got %0d acks, %0d overlaps want 4, 0",
               grants.size(), both);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (grants[i] != i % 2 || cycles[i] != 2 + 3 * i) begin
          tests_failed++;
          $display("FAIL tie_order[%0d]: port %0d at cycle %0d want port %0d at cycle %0d",
                   i, grants[i], cycles[i], i % 2, 2 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_single();
    set_req(1, 1, 5'd31, 32'h12345678);
    step();
    tests_run++;
    if (bus.busy !== 1'b1 || bus.mem_wE !== 1'b1 || bus.mem_address !== 5'd31) begin
      tests_failed++;
      $display("FAIL single_wr_grant: busy=%b we=%b a=%0d want 1 1 31",
               bus.busy, bus.mem_wE, bus.mem_address);
    end
    step();
    drop();
    step();
    set_req(1, 0, 5'd31, 32'd0);
    step();
    tests_run++;
    if (bus.mem_rE !== 1'b1 || bus.mem_address !== 5'd31) begin
      tests_failed++;
      $display("FAIL single_rd_grant: re=%b a=%0d want 1 31",
               bus.mem_rE, bus.mem_address);
    end
    step();
    tests_run++;
    if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 ||
        bus.rdata1 !== 32'h12345678 || bus.rdata0 !== 32'd0) begin
      tests_failed++;
      $display("FAIL single_rd_resp: ack1=%b ack0=%b r1=%h r0=%h want 1 0 12345678 0",
               bus.ack1, bus.ack0, bus.rdata1, bus.rdata0);
    end
    drop();
    step();
  endtask

  task automatic test_reset_mid();
    set_req(0, 0, 5'd31, 32'd0);
    step();
    tests_run++;
    if (bus.mem_rE !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_access: re=%b want 1", bus.mem_rE);
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (bus.mem_rE !== 1'b0 || bus.ack0 !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rdata0 !== 32'd0 || bus.rdata1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_reset: re=%b ack0=%b busy=%b r0=%h r1=%h want 0 0 0 0 0",
               bus.mem_rE, bus.ack0, bus.busy, bus.rdata0, bus.rdata1);
    end
    reset = 1'b0;
    drop();
    step();
    tests_run++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_ack: ack0=%b busy=%b want 0 0", bus.ack0, bus.busy);
    end
    set_req(0, 0, 5'd3, 32'd0);
    set_req(1, 0, 5'd4, 32'd0);
    step();
    step();
    tests_run++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_next_tie: ack0=%b ack1=%b want 1 0", bus.ack0, bus.ack1);
    end
    drop();
    step();
  endtask

  task automatic test_hold();
    set_req(0, 1, 5'd9, 32'hA5A5A5A5);
    step();
    step();
    drop();
    step();
    set_req(0, 0, 5'd9, 32'd0);
    step();
    step();
    tests_run++;
    if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL hold_read: ack0=%b r0=%h want 1 a5a5a5a5", bus.ack0, bus.rdata0);
    end
    drop();
    step();
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1, 5'(k), $urandom);
      for (int j = 0; j < 3; j++) begin
        step();
        if (j == 1) drop();
        tests_run++;
        if (bus.rdata0 !== 32'hA5A5A5A5) begin
          tests_failed++;
          $display("FAIL hold_rdata0[%0d.%0d]: got %h want a5a5a5a5",
                   k, j, bus.rdata0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [32];
    logic [31:0] exp_rd  [2];
    int          phase;
    bit          m_last;
    bit          m_win;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  exp_ctl;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    bit          acked;

    reset = 1'b1;
    drop();
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    phase  = 0;
    m_last = 1'b1;
    m_win  = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;

    for (int c = 0; c < 400; c++) begin
      // A transaction occupies three cycles: grant, memory access, ack.
      if (phase == 0) begin
        if (bus.req0 || bus.req1) begin
          m_win  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
          m_last = m_win;
          m_we   = m_win ? bus.we1    : bus.we0;
          m_addr = m_win ? bus.addr1  : bus.addr0;
          m_data = m_win ? bus.wdata1 : bus.wdata0;
          phase  = 1;
        end
      end else if (phase == 1) begin
        if (m_we) ref_mem[m_addr] = m_data;
        else      exp_rd[m_win]   = ref_mem[m_addr];
        phase = 2;
      end else begin
        phase = 0;
      end

      step();

      exp_ctl = {phase == 2 && !m_win, phase == 2 && m_win, phase != 0,
                 phase == 1 && !m_we, phase == 1 && m_we};
      exp_a = (phase == 1) ? m_addr : 5'd0;
      exp_d = (phase == 1 && m_we) ? m_data : 32'd0;

      tests_run++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.mem_rE, bus.mem_wE} !== exp_ctl) begin
        tests_failed++;
        $display("FAIL rand_ctl@%0d: ack0,ack1,busy,re,we=%b want %b", c,
                 {bus.ack0, bus.ack1, bus.busy, bus.mem_rE, bus.mem_wE}, exp_ctl);
      end
      tests_run++;
      if (bus.mem_address !== exp_a || bus.mem_data !== exp_d) begin
        tests_failed++;
        $display("FAIL rand_bus@%0d: a=%0d d=%h want a=%0d d=%h", c,
                 bus.mem_address, bus.mem_data, exp_a, exp_d);
      end
      tests_run++;
      if (bus.rdata0 !== exp_rd[0] || bus.rdata1 !== exp_rd[1]) begin
        tests_failed++;
        $display("FAIL rand_rdata@%0d: r0=%h r1=%h want %h %h", c,
                 bus.rdata0, bus.rdata1, exp_rd[0], exp_rd[1]);
      end

      acked = (phase == 2);
      if (acked) begin
        if (m_win) bus.req1 = 1'b0;
        else       bus.req0 = 1'b0;
      end
      if (!bus.req0 && !(acked && !m_win) && $urandom_range(1) == 1)
        set_req(0, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
      if (!bus.req1 && !(acked && m_win) && $urandom_range(1) == 1)
        set_req(1, 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
    end
    drop();
    step();
    step();
  endtask

  initial begin
    reset      = 1'b1;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.we0    = 1'b0;
    bus.we1    = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    test_reset();
    test_write_read();
    test_tie();
    test_single();
    test_reset_mid();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2port.md
# mem_arbiter_2port

Two-requester round-robin arbiter and sequencer for the 32-bit × 32-word memory module. Each requester presents a single-word read or write with a req/ack handshake. The block serialises requests, drives the memory's `data`, `address`, `rE`, `wE` and `reset` pins from registers, captures read data, and returns it to the granted requester.

## Interface
- `ADDR_W`, default 5: memory address width.
- `DATA_W`, default 32: memory word width.
- `clock` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `req0`, `req1` in, 1: request from requester 0/1; held high until the matching ack.
- `we0`, `we1` in, 1: 1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1` in, `ADDR_W`: word address; stable while req is high.
- `wdata0`, `wdata1` in, `DATA_W`: write data; stable while req is high.
- `ack0`, `ack1` out, 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out, `DATA_W`: last read result for that requester; held until that requester's next read completes.
- `busy` out, 1: high whenever the state is not IDLE.
- `mem_data` out, `DATA_W`: to the memory's `data` pin.
- `mem_address` out, `ADDR_W`: to the memory's `address` pin.
- `mem_rE`, `mem_wE` out, 1: to the memory's `rE`/`wE` pins.
- `mem_reset` out, 1: to the memory's `reset` pin; combinational copy of `reset`.
- `mem_dataOut` in, `DATA_W`: from the memory's `dataOut` pin.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise, select a winner:
    - Only one req high: that requester wins.
    - Both high: the requester other than `last_grant` wins.
  - Latch the winner's id, we, addr and wdata; set `last_grant` to the winner; go to ACCESS.
- Memory outputs in ACCESS:
  - `mem_address` = latched addr.
  - `mem_wE` = latched we; `mem_rE` = not latched we.
  - `mem_data` = latched wdata for writes, 0 for reads.
  - All `mem_*` outputs except `mem_reset` are registered. They are 0 in IDLE and RESP.
- ACCESS always lasts exactly one cycle, then goes to RESP. On the ACCESS→RESP edge, a read loads `mem_dataOut` into the winner's `rdata`. A write leaves both `rdata` registers unchanged.
- RESP: ack of the winner is high for this one cycle; the next state is unconditionally IDLE.
- Requests are sampled only in IDLE. A req held high in the cycle after its ack is a new request.
- Sustained throughput is one transaction per 3 cycles.
- Requester id is 1 bit; no other arithmetic.
- Invalid state encodings return to IDLE on the next edge.

## Timing
- Reset values at the first edge with `reset`=1:
  - state = IDLE; `last_grant` = 1, so requester 0 wins the first tie.
  - `ack0`, `ack1` = 0; `rdata0`, `rdata1` = 0; `busy` = 0.
  - `mem_data` = 0, `mem_address` = 0, `mem_rE` = 0, `mem_wE` = 0.
  - `mem_reset` follows `reset` in the same cycle.
- Latency, with req sampled high in IDLE during cycle n:
  - cycle n+1: ACCESS; memory strobe high.
  - cycle n+2: RESP; ack high and `rdata` valid.
- Reset asserted in ACCESS or RESP aborts the transaction:
  - No ack is issued.
  - Strobes are 0 from the reset edge.
  - `rdata` is cleared.
  - A write may already have been committed to memory, but the memory is cleared by `mem_reset` anyway.
- Requests presented while `busy` is high wait; there is no queueing beyond the held req.
- A requester that drops req before its ack, outside IDLE, is still served. Requesters must not do this.

## Test plan
- Reset: hold `reset` 2 cycles with `req0`=`req1`=1 → all outputs 0 and `mem_reset`=1 during reset; after release, requester 0 is granted first.
- Write then read on port 0:
  - Stimulus: write addr 5, data 0xDEADBEEF, then read addr 5.
  - Required: `mem_wE`=1 for exactly one cycle with `mem_address`=5, `mem_data`=0xDEADBEEF; `ack0` 2 cycles after sampling; the read returns `rdata0`=0xDEADBEEF with `ack0`; `rdata1` stays 0.
- Tie fairness: `req0`, `req1` both held high continuously for 12 cycles → grants alternate 0,1,0,1. Each ack arrives every 6 cycles, and `ack0`/`ack1` are never high together.
- Single requester: only `req1` high, reading addr 31 preloaded with 0x12345678 → granted without waiting for 0; `rdata1`=0x12345678; `rdata0` unchanged.
- Reset mid-operation: assert `reset` in the ACCESS cycle of a read → no ack; `mem_rE`=0 the next cycle; state IDLE; the next tie goes to requester 0.
- Hold: after port 0 reads 0xA5A5A5A5, port 1 performs three writes → `rdata0` remains 0xA5A5A5A5 throughout.
